// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_BLOCKED = 2'd2
  } fetch_state_e;

  // Instruction presented when nothing has been fetched yet.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Sequential fetch increment in bytes.
  localparam int unsigned PC_INC = 4;

  // Mask with the low 'bits' bits set; used to clear PC bits above the
  // implemented address range.
  function automatic logic [63:0] low_mask(input int unsigned bits);
    if (bits >= 64) begin
      return '1;
    end
    return (64'd1 << bits) - 64'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request bus and decode-side output handshake.
interface instr_fetch_unit_if #(
  parameter int N = 32
);
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ack;
  logic [N-1:0] imem_rdata;
  logic         stall;
  logic         inst_valid;
  logic [N-1:0] inst_out;
  logic [N-1:0] inst_pc;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_ack, imem_rdata, stall
  );

  // Memory/decode side.
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_ack, imem_rdata, stall
  );
endinterface

// File: rtl/instr_fetch_unit_skid.sv
// Output register plus one skid entry between fetch and decode.
// The controller decides which action applies each cycle; this block only
// applies it with flush taking precedence over everything else.
module fetch_skid_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,      // write incoming word into output register
  input  logic         push,      // write incoming word into skid register
  input  logic         pop,       // move skid word into output register
  input  logic         flush,     // discard output and skid contents
  input  logic         stall,     // decode not consuming the output this cycle
  input  logic [N-1:0] in_data,
  input  logic [N-1:0] in_pc,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [N-1:0] out_pc
);

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic [N-1:0] out_pc_q, out_pc_d;
  logic         skid_valid_q, skid_valid_d;
  logic [N-1:0] skid_data_q, skid_data_d;
  logic [N-1:0] skid_pc_q, skid_pc_d;

  // Next contents of the output and skid registers.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop && skid_valid_q) begin
      out_valid_d  = 1'b1;
      out_data_d   = skid_data_q;
      out_pc_d     = skid_pc_q;
      skid_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_pc_d    = in_pc;
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_pc_d    = in_pc;
    end else if (!stall) begin
      // Decode consumed the word and nothing replaces it.
      out_valid_d = 1'b0;
    end
  end

  // Register update with synchronous reset to an empty buffer showing NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= N'(NOP);
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_pc    = out_pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues req/ack reads at the PC, chooses the next PC and
// hands fetched words to decode through a one-deep skid buffer. The PC
// register has no enable, so holding the PC means driving new_pc = pc_value.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int N         = 32,
  parameter int ADDR_BITS = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        pc_value,
  output logic [N-1:0]        new_pc,
  input  logic                branch_taken,
  input  logic [N-1:0]        branch_target,
  input  logic                jump,
  input  logic [N-1:0]        jump_target,
  instr_fetch_unit_if.master  bus
);

  localparam logic [N-1:0] ADDR_MASK = N'(low_mask(ADDR_BITS));

  fetch_state_e state_q, state_d;
  logic [N-1:0] imem_addr_q, imem_addr_d;
  logic         drop_q, drop_d;

  logic         buf_load, buf_push, buf_pop, buf_flush;
  logic         buf_valid;
  logic [N-1:0] buf_data, buf_pc;

  logic         redirect;
  logic [N-1:0] redirect_pc;
  logic [N-1:0] hold_pc;
  logic [N-1:0] seq_pc;

  // Candidate next-PC values; jump wins over branch.
  always_comb begin
    redirect    = jump | branch_taken;
    redirect_pc = (jump ? jump_target : branch_target) & ADDR_MASK;
    hold_pc     = pc_value & ADDR_MASK;
    seq_pc      = (pc_value + N'(PC_INC)) & ADDR_MASK;
  end

  // Next state, request address, drop flag, next PC and buffer controls.
  always_comb begin
    state_d     = state_q;
    imem_addr_d = imem_addr_q;
    drop_d      = drop_q;
    new_pc      = hold_pc;
    buf_load    = 1'b0;
    buf_push    = 1'b0;
    buf_pop     = 1'b0;
    buf_flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        imem_addr_d = hold_pc;
        state_d     = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect) begin
          new_pc    = redirect_pc;
          buf_flush = 1'b1;
          if (bus.imem_ack) begin
            // Word returned this cycle belongs to the old path: discard it.
            imem_addr_d = redirect_pc;
            drop_d      = 1'b0;
          end else begin
            // Request stays on the bus; its late data must be dropped.
            drop_d = 1'b1;
          end
        end else if (bus.imem_ack) begin
          if (drop_q) begin
            drop_d      = 1'b0;
            imem_addr_d = hold_pc;
          end else begin
            new_pc = seq_pc;
            if (!buf_valid || !bus.stall) begin
              buf_load    = 1'b1;
              imem_addr_d = seq_pc;
            end else begin
              buf_push = 1'b1;
              state_d  = ST_BLOCKED;
            end
          end
        end
      end
      ST_BLOCKED: begin
        if (redirect) begin
          new_pc      = redirect_pc;
          buf_flush   = 1'b1;
          imem_addr_d = redirect_pc;
          state_d     = ST_FETCH;
        end else if (!bus.stall) begin
          buf_pop     = 1'b1;
          imem_addr_d = hold_pc;
          state_d     = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      new_pc = '0;
    end
  end

  // Controller state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      imem_addr_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_addr_q <= imem_addr_d;
      drop_q      <= drop_d;
    end
  end

  fetch_skid_buffer #(.N(N)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .push      (buf_push),
    .pop       (buf_pop),
    .flush     (buf_flush),
    .stall     (bus.stall),
    .in_data   (bus.imem_rdata),
    .in_pc     (imem_addr_q),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .out_pc    (buf_pc)
  );

  assign bus.imem_req   = (state_q == ST_FETCH);
  assign bus.imem_addr  = imem_addr_q;
  assign bus.inst_valid = buf_valid;
  assign bus.inst_out   = buf_data;
  assign bus.inst_pc    = buf_pc;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage between the 32-bit PC register and instruction decode. Issues a req/ack read to instruction memory at the current PC and computes the next PC (PC+4, branch or jump target). Buffers one fetched instruction plus one skid entry, so a decode stall never loses data. The PC register has no enable, so this block holds the PC by driving new_pc = pc_value whenever the PC must not advance.

Parameters:
N, 32, datapath/PC width
ADDR_BITS, 20, significant PC bits; new_pc and imem_addr are zero above bit ADDR_BITS-1

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
pc_value  in  N  current PC from PC register
new_pc  out  N  next PC to PC register (combinational)
imem_req  out  1  read request, held high until imem_ack
imem_addr  out  N  registered request address, stable while imem_req=1
imem_ack  in  1  memory data valid this cycle
imem_rdata  in  N  instruction word
stall  in  1  decode cannot accept inst_out this cycle
branch_taken  in  1  branch redirect
branch_target  in  N  branch target
jump  in  1  jump redirect
jump_target  in  N  jump target
inst_valid  out  1  inst_out/inst_pc valid
inst_out  out  N  fetched instruction
inst_pc  out  N  address of inst_out

Behaviour:
- Reset (clk edge with reset=1): state IDLE; imem_req=0; imem_addr=0; inst_valid=0; inst_out=0x00000000 (NOP); inst_pc=0; skid empty; drop=0. new_pc=0 while reset=1. Reset mid-transaction abandons it; a late imem_ack after reset is ignored in IDLE.
- States:
  - IDLE: imem_req=0. Next edge: imem_addr<=pc_value masked, imem_req<=1, go to FETCH.
  - FETCH: imem_req=1, imem_addr held stable until imem_ack.
  - BLOCKED: imem_req=0. Skid full, decode stalled.
- Ack in FETCH, drop=0:
  - If inst_valid=0 or stall=0: write the word into the output buffer.
  - Otherwise: write it into skid and go to BLOCKED.
  - new_pc = pc_value+4 in the ack cycle, computed in N bits, masked to ADDR_BITS; 0x000FFFFC wraps to 0.
  - If not going to BLOCKED: imem_addr<=new_pc and stay in FETCH, so a new transaction starts the next cycle. Back-to-back acks give one instruction per cycle.
- Ack with drop=1: discard the data; clear drop; imem_addr<=pc_value; new_pc=pc_value.
- No ack in FETCH: new_pc=pc_value.
- Output buffer: inst_valid clears when stall=0 and no new word is loaded.
- BLOCKED: new_pc=pc_value. On stall=0: output<=skid, skid empty, imem_addr<=pc_value, imem_req<=1, go to FETCH.
- Redirect (jump has priority over branch_taken), any state except IDLE:
  - new_pc = selected target masked; flush the output buffer and skid (inst_valid=0 next cycle). Flush overrides stall.
  - In FETCH without ack: set drop, keep imem_addr and imem_req unchanged, remain in FETCH.
  - In FETCH with ack, or in BLOCKED: next state FETCH with imem_addr<=target.
- Redirect and ack in the same cycle: the word is discarded, never delivered.

Decomposition:
- Package: state encoding (IDLE, FETCH, BLOCKED), NOP constant 0x00000000, PC_INC=4, address-mask function.
- One sub-module: fetch_skid_buffer (output register + skid register, load/stall/flush inputs).
- FSM, drop flag and next-PC mux live in instr_fetch_unit.

Test Plan:
- Reset, then pc_value=0 with memory acking one cycle after req -> imem_addr 0x0, 0x4, 0x8; inst_pc matches each address; new_pc=pc_value+4 only in ack cycles.
- Zero-wait memory (ack whenever req=1), stall=0 -> one instruction per cycle, imem_req stays high, inst_out follows memory words in order.
- Hold stall=1 over two acks -> second word enters skid, state BLOCKED, imem_req=0, new_pc=pc_value; release stall -> skid word appears next cycle, fetch resumes at the next address.
- Pulse branch_taken (target 0x100) while a request to 0x8 is outstanding -> new_pc=0x100 that cycle; the late 0x8 data is never presented; next request address 0x100. Also pulse jump and branch together -> jump_target wins.
- pc_value=0x000FFFFC, ack -> new_pc=0x00000000; pc_value=0x12345678 -> imem_addr=0x00045678.
- Assert reset during FETCH with ack arriving the next cycle -> inst_valid=0, imem_req=0 after the edge; no instruction delivered; fetch restarts at 0 after IDLE.
